alu_op_sequencer: RTL and testbench



---
 rtl/alu_op_sequencer.sv | 128 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Issue-side sequencer for the 8-bit dALU: accepts packed instructions, drives the ALU for one cycle, writes back and presents the result.
// Optional debug read port of the register file is enabled by defining ALU_SEQ_DBG_EN.
//
// state | meaning
// IDLE  | ready for an instruction word
// EXEC  | ALU driven from latched instruction, writeback at closing edge
// RESP  | result held on res_* until res_ready
module alu_op_sequencer #(
  parameter int DATA_W = 8,
  parameter int RA_W = 2,
  localparam int INSTR_W = 2 + 3*RA_W + DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [1:0]         alu_op,
  input  logic [DATA_W-1:0]  alu_out,
  input  logic               alu_carry,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [DATA_W-1:0]  res_data,
  output logic [RA_W-1:0]    res_rd,
  output logic               flag_zero,
  output logic               flag_carry
`ifdef ALU_SEQ_DBG_EN
  ,
  input  logic [RA_W-1:0]    dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
`endif
);

  localparam int NREG = 2**RA_W;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [INSTR_W-1:0] r_instr;
  logic [DATA_W-1:0]  r_regs [NREG];
  logic [DATA_W-1:0]  r_res_data;
  logic [RA_W-1:0]    r_res_rd;
  logic               r_flag_zero;
  logic               r_flag_carry;

  logic [1:0]         w_op;
  logic [RA_W-1:0]    w_rd;
  logic [RA_W-1:0]    w_rs;
  logic [RA_W-1:0]    w_rt;
  logic [DATA_W-1:0]  w_imm;
  logic [DATA_W-1:0]  w_wr_val;

  assign w_op  = r_instr[INSTR_W-1 -: 2];
  assign w_rd  = r_instr[DATA_W+3*RA_W-1 -: RA_W];
  assign w_rs  = r_instr[DATA_W+2*RA_W-1 -: RA_W];
  assign w_rt  = r_instr[DATA_W+RA_W-1 -: RA_W];
  assign w_imm = r_instr[DATA_W-1:0];

  // LDI bypasses the ALU result entirely
  assign w_wr_val = (w_op == 2'd0) ? w_imm : alu_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    res_valid   = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = 2'd0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = EXEC;
      end
      EXEC: begin
        alu_a       = r_regs[w_rs];
        alu_b       = r_regs[w_rt];
        alu_op      = w_op;
        w_state_nxt = RESP;
      end
      RESP: begin
        res_valid = 1'b1;
        if (res_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr      <= '0;
      r_res_data   <= '0;
      r_res_rd     <= '0;
      r_flag_zero  <= 1'b0;
      r_flag_carry <= 1'b0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      if (r_state == IDLE && in_valid) r_instr <= in_instr;
      if (r_state == EXEC) begin
        r_regs[w_rd] <= w_wr_val;
        r_res_data   <= w_wr_val;
        r_res_rd     <= w_rd;
        r_flag_zero  <= (w_wr_val == '0);
        if (w_op == 2'd3) r_flag_carry <= alu_carry;
      end
    end
  end

  assign res_data   = r_res_data;
  assign res_rd     = r_res_rd;
  assign flag_zero  = r_flag_zero;
  assign flag_carry = r_flag_carry;

`ifdef ALU_SEQ_DBG_EN
  assign dbg_data = r_regs[dbg_addr];
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: a behavioural register-file model predicts each result,
// a monitor pops predictions on every result handshake; directed plan cases then random traffic.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [7:0]  alu_a, alu_b;
  logic [1:0]  alu_op;
  logic [7:0]  alu_out;
  logic        alu_carry;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;
  logic [1:0]  res_rd;
  logic        flag_zero, flag_carry;
`ifdef ALU_SEQ_DBG_EN
  logic [1:0]  dbg_addr;
  logic [7:0]  dbg_data;
`endif

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_rd(res_rd),
    .flag_zero(flag_zero), .flag_carry(flag_carry)
`ifdef ALU_SEQ_DBG_EN
    , .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`endif
  );

  always #5 clk = ~clk;

  // combinational ALU stand-in
  always_comb begin
    case (alu_op)
      2'd1:    {alu_carry, alu_out} = {1'b0, alu_a | alu_b};
      2'd2:    {alu_carry, alu_out} = {1'b0, alu_a & alu_b};
      2'd3:    {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      default: {alu_carry, alu_out} = 9'd0;
    endcase
  end

  typedef struct {
    logic [7:0] data;
    logic [1:0] rd;
    logic       z;
    logic       c;
  } exp_t;

  exp_t       q[$];
  logic [7:0] m_regs [4];
  logic       m_c;
  int         total = 0;
  int         bad = 0;
  bit         rr_rand = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_c = 1'b0;
  endtask

  // monitor: a handshake seen here completes at the coming rising edge
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 32'(res_data), 32'hDEAD);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("res_data", 32'(res_data), 32'(e.data));
        chk("res_rd", 32'(res_rd), 32'(e.rd));
        chk("flag_zero", 32'(flag_zero), 32'(e.z));
        chk("flag_carry", 32'(flag_carry), 32'(e.c));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rr_rand) res_ready = ($urandom_range(0, 3) != 0);
  end

  // drives one instruction, predicts its result, and checks the ALU ports in its EXEC cycle
  task automatic issue(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic [1:0] rt, input logic [7:0] imm);
    logic [7:0] a, b, wr;
    logic [8:0] sum;
    int         n;
    exp_t       e;
    @(posedge clk); #1;
    in_instr = {op, rd, rs, rt, imm};
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    a = m_regs[rs];
    b = m_regs[rt];
    case (op)
      2'd0: wr = imm;
      2'd1: wr = a | b;
      2'd2: wr = a & b;
      default: begin
        sum = {1'b0, a} + {1'b0, b};
        wr  = sum[7:0];
        m_c = sum[8];
      end
    endcase
    m_regs[rd] = wr;
    e.data = wr; e.rd = rd; e.z = (wr == 8'h00); e.c = m_c;
    q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("exec_alu_a", 32'(alu_a), 32'(a));
    chk("exec_alu_b", 32'(alu_b), 32'(b));
    chk("exec_alu_op", 32'(alu_op), 32'(op));
    chk("exec_in_ready", 32'(in_ready), 32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_res_data"}, 32'(res_data), 32'd0);
    chk({tag, "_res_rd"}, 32'(res_rd), 32'd0);
    chk({tag, "_flag_zero"}, 32'(flag_zero), 32'd0);
    chk({tag, "_flag_carry"}, 32'(flag_carry), 32'd0);
    chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
    chk({tag, "_alu_a"}, 32'(alu_a), 32'd0);
    chk({tag, "_alu_b"}, 32'(alu_b), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = 16'h0; res_ready = 1'b1;
`ifdef ALU_SEQ_DBG_EN
    dbg_addr = 2'd0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");
`ifdef ALU_SEQ_DBG_EN
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i); #1;
      chk("reset_dbg_reg", 32'(dbg_data), 32'h00);
    end
`endif

    // directed plan: LDI, OR, AND, ADD
    issue(2'd0, 2'd1, 2'd0, 2'd0, 8'h02);
    issue(2'd0, 2'd2, 2'd0, 2'd0, 8'h03);
    issue(2'd1, 2'd3, 2'd1, 2'd2, 8'h00);
    issue(2'd2, 2'd0, 2'd1, 2'd2, 8'h00);
    issue(2'd3, 2'd3, 2'd1, 2'd2, 8'h00);
    // ADD overflow to zero, then OR must keep carry
    issue(2'd0, 2'd1, 2'd0, 2'd0, 8'hFF);
    issue(2'd0, 2'd2, 2'd0, 2'd0, 8'h01);
    issue(2'd3, 2'd0, 2'd1, 2'd2, 8'h00);
    issue(2'd1, 2'd3, 2'd1, 2'd2, 8'h00);
    // hazard: source equals destination reads the old value
    issue(2'd3, 2'd1, 2'd1, 2'd1, 8'h00);
    drain();

    // backpressure with a stray in_valid pulse while RESP
    res_ready = 1'b0;
    issue(2'd0, 2'd1, 2'd0, 2'd0, 8'h5A);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_res_valid", 32'(res_valid), 32'd1);
      chk("bp_res_data", 32'(res_data), 32'h5A);
      chk("bp_res_rd", 32'(res_rd), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      in_instr = {2'd0, 2'd2, 2'd0, 2'd0, 8'h77};
      in_valid = (i == 1);
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_release_res_valid", 32'(res_valid), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    drain();
    // R2 must still hold 0x01 if the stray pulse was ignored
    issue(2'd1, 2'd0, 2'd2, 2'd2, 8'h00);
    drain();

    // reset during EXEC of ADD R3
    issue(2'd0, 2'd3, 2'd0, 2'd0, 8'h44);
    drain();
    @(posedge clk); #1;
    in_instr = {2'd3, 2'd3, 2'd1, 2'd2, 8'h00};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_res_valid", 32'(res_valid), 32'd0);
`ifdef ALU_SEQ_DBG_EN
    dbg_addr = 2'd3; #1;
    chk("post_reset_dbg_r3", 32'(dbg_data), 32'h00);
`endif
    issue(2'd1, 2'd0, 2'd3, 2'd3, 8'h00);
    drain();

    // random traffic with random consumer stalls
    rr_rand = 1'b1;
    for (int i = 0; i < 200; i++) begin
      issue(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    end
    rr_rand = 1'b0;
    res_ready = 1'b1;
    drain();
`ifdef ALU_SEQ_DBG_EN
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i); #1;
      chk("final_dbg_reg", 32'(dbg_data), 32'(m_regs[i]));
    end
`endif
    repeat (3) @(negedge clk);
    chk("no_extra_results", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
